// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Boot-time program loader. Assembles a UART byte stream
//             (4-byte word count, N little-endian payload words, XOR
//             checksum byte) into 32-bit words, writes them to consecutive
//             text-memory word addresses and releases the core reset only
//             once the whole image has been checksum-verified.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Loader states
    localparam logic [2:0] c_ST_HDR  = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_CHK  = 3'd2;
    localparam logic [2:0] c_ST_DONE = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;

    // Largest legal word count: the full text memory
    localparam logic [32:0] c_CAPACITY = 33'd1 << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;

    logic [1:0]            r_byte_cnt;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic [ADDR_WIDTH:0]   r_nwords;
    logic [23:0]           r_shift;
    logic [7:0]            r_csum;

    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_core_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [31:0]           w_word;
    logic                  w_last_byte;
    logic [ADDR_WIDTH:0]   w_word_inc;
    logic                  w_collect;

    // The incoming byte lands in the top lane, so after four bytes the
    // first one received sits in [7:0] (little-endian assembly).
    assign w_word      = {rx_data, r_shift};
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_word_inc  = r_word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_collect   = rx_valid && ((r_state == c_ST_HDR) || (r_state == c_ST_LOAD));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; every transition is triggered by a received byte
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_HDR: begin
                if (rx_valid && w_last_byte) begin
                    if ({1'b0, w_word} > c_CAPACITY) begin
                        w_state_next = c_ST_ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_next = c_ST_CHK;
                    end else begin
                        w_state_next = c_ST_LOAD;
                    end
                end
            end
            c_ST_LOAD: begin
                if (rx_valid && w_last_byte && (w_word_inc == r_nwords)) begin
                    w_state_next = c_ST_CHK;
                end
            end
            c_ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == r_csum) begin
                        w_state_next = c_ST_DONE;
                    end else begin
                        w_state_next = c_ST_ERR;
                    end
                end
            end
            c_ST_DONE: w_state_next = c_ST_DONE;
            c_ST_ERR:  w_state_next = c_ST_ERR;
            default:   w_state_next = c_ST_HDR;
        endcase
    end

    // Byte assembly, counters and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_word_cnt <= '0;
            r_nwords   <= '0;
            r_shift    <= 24'd0;
            r_csum     <= 8'd0;
        end else if (w_collect) begin
            r_shift    <= w_word[31:8];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_state == c_ST_HDR) begin
                if (w_last_byte) begin
                    // Only meaningful when the count is in range; an
                    // oversized count goes straight to the error state.
                    r_nwords   <= w_word[ADDR_WIDTH:0];
                    r_word_cnt <= '0;
                end
            end else begin
                r_csum <= r_csum ^ rx_data;
                if (w_last_byte) begin
                    r_word_cnt <= w_word_inc;
                end
            end
        end
    end

    // Memory write port: one registered pulse per completed payload word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_collect && (r_state == c_ST_LOAD) && w_last_byte) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                r_mem_wdata <= w_word;
            end
        end
    end

    // Status flags and core reset; done/err are sticky until rst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (rx_valid && (r_state == c_ST_HDR)) begin
                r_busy <= 1'b1;
            end
            if ((w_state_next == c_ST_DONE) && (r_state != c_ST_DONE)) begin
                r_done     <= 1'b1;
                r_core_rst <= 1'b0;
                r_busy     <= 1'b0;
            end
            if ((w_state_next == c_ST_ERR) && (r_state != c_ST_ERR)) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign core_rst  = r_core_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Self-checking bench for prog_loader. A byte-indexed frame
//             model predicts every output each cycle; directed frames plus
//             randomized frames exercise loading, checksum, length limits,
//             mid-load reset and post-completion immunity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int     ADDR_WIDTH = 8;
    localparam longint c_CAP      = 64'd1 << ADDR_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [7:0]            rx_data = 8'd0;
    logic                  rx_valid = 1'b0;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [31:0]           w_mem_wdata;
    logic                  w_core_rst;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_err;

    prog_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (w_mem_we),
        .mem_addr  (w_mem_addr),
        .mem_wdata (w_mem_wdata),
        .core_rst  (w_core_rst),
        .busy      (w_busy),
        .done      (w_done),
        .err       (w_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit                    m_busy, m_done, m_err, m_core_rst, m_exp_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [31:0]           m_wdata, m_word;
    logic [7:0]            m_csum;
    longint                m_n, m_idx;
    bit                    chk_en = 1'b0;

    logic [ADDR_WIDTH+31:0] obs_q[$];
    logic [31:0]            g_words[$];

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_core_rst = 1; m_exp_we = 0;
        m_addr = '0; m_wdata = '0; m_word = '0; m_csum = '0;
        m_n = 0; m_idx = 0;
    endtask

    // Interpret byte number m_idx of the frame
    task automatic model_byte(input logic [7:0] b);
        longint p;
        if (m_done || m_err) return;
        if (m_idx < 4) begin
            m_n    = m_n | (longint'(b) << (8 * m_idx));
            m_busy = 1;
            if (m_idx == 3 && m_n > c_CAP) begin
                m_err  = 1;
                m_busy = 0;
            end
        end else if (m_idx - 4 < 4 * m_n) begin
            p = m_idx - 4;
            m_csum = m_csum ^ b;
            m_word[8 * (p % 4) +: 8] = b;
            if (p % 4 == 3) begin
                m_exp_we = 1;
                m_addr   = ADDR_WIDTH'(p / 4);
                m_wdata  = m_word;
            end
        end else begin
            if (b == m_csum) begin
                m_done     = 1;
                m_core_rst = 0;
            end else begin
                m_err = 1;
            end
            m_busy = 0;
        end
        m_idx++;
    endtask

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] c = 8'd0;
        for (int i = 0; i < n; i++) begin
            c = c ^ g_words[i][7:0] ^ g_words[i][15:8] ^ g_words[i][23:16] ^ g_words[i][31:24];
        end
        return c;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_we",    32'(w_mem_we),    32'(m_exp_we));
            check("mem_addr",  32'(w_mem_addr),  32'(m_addr));
            check("mem_wdata", w_mem_wdata,      m_wdata);
            check("core_rst",  32'(w_core_rst),  32'(m_core_rst));
            check("busy",      32'(w_busy),      32'(m_busy));
            check("done",      32'(w_done),      32'(m_done));
            check("err",       32'(w_err),       32'(m_err));
            if (w_mem_we === 1'b1) obs_q.push_back({w_mem_addr, w_mem_wdata});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        m_exp_we = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        m_exp_we = 0;
        model_byte(b);
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        obs_q.delete();
        tick();
    endtask

    task automatic send_header(input longint n);
        for (int i = 0; i < 4; i++) send_byte(8'(n >> (8 * i)));
    endtask

    task automatic send_words(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) send_byte(8'(g_words[i] >> (8 * k)));
    endtask

    task automatic fill_words(input int n);
        g_words.delete();
        for (int i = 0; i < n; i++) g_words.push_back($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] v;
        int          n, cut;
        model_reset();

        // Reset state
        do_reset();
        check("reset core_rst", 32'(w_core_rst), 32'd1);
        check("reset mem_addr", 32'(w_mem_addr), 32'd0);
        check("reset busy",     32'(w_busy),     32'd0);

        // Nominal load: payload bytes 93 00 50 00 33 81 10 00 XOR to 0x61
        g_words.delete();
        g_words.push_back(32'h00500093);
        g_words.push_back(32'h00108133);
        check("model csum", 32'(csum_of(2)), 32'h61);
        send_header(2);
        send_words(2);
        send_byte(8'h61);
        check("nominal writes", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) begin
            check("nominal w0", 32'(obs_q[0][ADDR_WIDTH+31:32]), 32'd0);
            check("nominal d0", obs_q[0][31:0], 32'h00500093);
            check("nominal w1", 32'(obs_q[1][ADDR_WIDTH+31:32]), 32'd1);
            check("nominal d1", obs_q[1][31:0], 32'h00108133);
        end
        check("nominal done",     32'(w_done),     32'd1);
        check("nominal core_rst", 32'(w_core_rst), 32'd0);

        // Post-done immunity
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        check("immune writes", obs_q.size(), 32'd2);
        check("immune done",   32'(w_done), 32'd1);

        // Bad checksum
        do_reset();
        send_header(2);
        send_words(2);
        send_byte(8'h00);
        check("badcs writes",   obs_q.size(), 32'd2);
        check("badcs err",      32'(w_err), 32'd1);
        check("badcs core_rst", 32'(w_core_rst), 32'd1);
        check("badcs done",     32'(w_done), 32'd0);

        // Length overflow
        do_reset();
        send_header(257);
        check("ovf err", 32'(w_err), 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        check("ovf writes", obs_q.size(), 32'd0);

        // N = 0
        do_reset();
        send_header(0);
        send_byte(8'h00);
        check("n0 done",   32'(w_done), 32'd1);
        check("n0 writes", obs_q.size(), 32'd0);

        // N = full capacity
        do_reset();
        fill_words(256);
        send_header(256);
        send_words(256);
        send_byte(csum_of(256));
        check("full writes", obs_q.size(), 32'd256);
        if (obs_q.size() == 256)
            check("full last addr", 32'(obs_q[255][ADDR_WIDTH+31:32]), 32'hFF);
        check("full done", 32'(w_done), 32'd1);

        // Reset mid-load, then a complete one-word frame
        do_reset();
        fill_words(2);
        send_header(2);
        for (int i = 0; i < 6; i++) send_byte(8'(g_words[i / 4] >> (8 * (i % 4))));
        do_reset();
        fill_words(1);
        send_header(1);
        send_words(1);
        send_byte(csum_of(1));
        check("restart writes", obs_q.size(), 32'd1);
        if (obs_q.size() == 1)
            check("restart addr", 32'(obs_q[0][ADDR_WIDTH+31:32]), 32'd0);
        check("restart done",     32'(w_done), 32'd1);
        check("restart core_rst", 32'(w_core_rst), 32'd0);

        // Randomized frames, checked cycle-by-cycle by the model
        for (int t = 0; t < 25; t++) begin
            do_reset();
            n = $urandom_range(0, 6);
            fill_words(n);
            if ($urandom_range(0, 5) == 0) begin
                send_header(longint'($urandom_range(257, 100000)));
                for (int i = 0; i < 5; i++) send_byte(8'($urandom));
            end else begin
                cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4 * n + 4)) : -1;
                send_header(n);
                for (int i = 0; i < 4 * n; i++) begin
                    if (i == cut) do_reset();
                    send_byte(8'(g_words[i / 4] >> (8 * (i % 4))));
                end
                v = 32'(csum_of(n));
                if ($urandom_range(0, 2) == 0) v = v ^ 32'(8'($urandom_range(1, 255)));
                send_byte(v[7:0]);
                for (int i = 0; i < 3; i++) send_byte(8'($urandom));
            end
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
